// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port byte-write-enable SRAM arbiter.
// Request payloads are carried at a fixed maximum width; the arbiter
// narrows them to its configured DWIDTH/AWIDTH at the RAM boundary.
package sram_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned REQ_AW_MAX = 32;
  localparam int unsigned REQ_DW_MAX = 256;
  localparam int unsigned REQ_BW_MAX = REQ_DW_MAX / 8;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

  typedef struct packed {
    logic [REQ_AW_MAX-1:0] addr;
    logic [REQ_DW_MAX-1:0] wdata;
    logic [REQ_BW_MAX-1:0] wbe;
  } sram_req_t;

  // With two ports the "other" port is simply the complement of the index.
  function automatic port_idx_t other_port(input port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/sram_arb_port.sv
// Per-requester response tracking: one-cycle in-flight flag plus a holding
// register used when the requester does not consume in the first cycle.
// The response is visible straight from ram_q in the cycle after the grant,
// so the holding register only captures it if the requester stalls.
module sram_arb_port
  #(parameter int unsigned DWIDTH = 32)
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              resp_ready,
    input  logic [DWIDTH-1:0] ram_q,
    output logic              eligible_c,
    output logic              resp_valid_c,
    output logic [DWIDTH-1:0] resp_rdata_c
  );

  logic              inflight;
  logic              held_valid;
  logic [DWIDTH-1:0] held_rdata;

  // In-flight flag lasts exactly the cycle in which ram_q carries our word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
    end
  end

  // Capture the RAM word if it is not consumed immediately; clear on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_rdata <= '0;
    end else if (inflight) begin
      if (!resp_ready) begin
        held_valid <= 1'b1;
        held_rdata <= ram_q;
      end
    end else if (held_valid && resp_ready) begin
      held_valid <= 1'b0;
      held_rdata <= '0;
    end
  end

  // Response view and eligibility for the arbiter.
  always_comb begin
    eligible_c   = !inflight && !held_valid;
    resp_valid_c = inflight || held_valid;
    resp_rdata_c = inflight ? ram_q : held_rdata;
  end

endmodule

// File: rtl/sram_wbe_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM with byte
// write enables. Every accepted request (read or write) returns one
// response carrying the word as it was before the access.
// Optional build macro SRAM_ARB_RR_EN selects round-robin tie breaking;
// otherwise port 0 wins every tie.
module sram_wbe_arbiter
  import sram_arb_pkg::*;
  #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 8
  )
  (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_0,
    output logic                req_ready_0,
    input  logic [AWIDTH-1:0]   req_addr_0,
    input  logic [DWIDTH-1:0]   req_wdata_0,
    input  logic [DWIDTH/8-1:0] req_wbe_0,
    output logic                resp_valid_0,
    input  logic                resp_ready_0,
    output logic [DWIDTH-1:0]   resp_rdata_0,
    input  logic                req_valid_1,
    output logic                req_ready_1,
    input  logic [AWIDTH-1:0]   req_addr_1,
    input  logic [DWIDTH-1:0]   req_wdata_1,
    input  logic [DWIDTH/8-1:0] req_wbe_1,
    output logic                resp_valid_1,
    input  logic                resp_ready_1,
    output logic [DWIDTH-1:0]   resp_rdata_1,
    output logic                ram_en,
    output logic [AWIDTH-1:0]   ram_addr,
    output logic [DWIDTH-1:0]   ram_d,
    output logic [DWIDTH/8-1:0] ram_wbe,
    input  logic [DWIDTH-1:0]   ram_q
  );

  localparam int unsigned BWIDTH = DWIDTH / 8;

  logic [NUM_PORTS-1:0] valid;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] grant;
  port_idx_t            win_idx;
  sram_req_t            req_s [NUM_PORTS];
  sram_req_t            win_req;
  logic                 unused_pad;

`ifdef SRAM_ARB_RR_EN
  port_idx_t            rr_ptr;
`endif

  assign valid = {req_valid_1, req_valid_0};

  // Widen each requester's fields into the common request payload.
  always_comb begin
    req_s[0].addr  = REQ_AW_MAX'(req_addr_0);
    req_s[0].wdata = REQ_DW_MAX'(req_wdata_0);
    req_s[0].wbe   = REQ_BW_MAX'(req_wbe_0);
    req_s[1].addr  = REQ_AW_MAX'(req_addr_1);
    req_s[1].wdata = REQ_DW_MAX'(req_wdata_1);
    req_s[1].wbe   = REQ_BW_MAX'(req_wbe_1);
  end

  // Pick at most one eligible, valid requester; an ineligible port never blocks.
  always_comb begin
    cand    = valid & eligible & {NUM_PORTS{rst_n}};
    win_idx = '0;
    grant   = '0;
`ifdef SRAM_ARB_RR_EN
    if (&cand) begin
      win_idx = rr_ptr;
    end else if (cand[1]) begin
      win_idx = port_idx_t'(1);
    end
`else
    if (!cand[0] && cand[1]) begin
      win_idx = port_idx_t'(1);
    end
`endif
    if (|cand) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign win_req     = req_s[win_idx];
  assign unused_pad  = ^win_req;

  // Drive the RAM in the same cycle as the grant; idle cycles are quiet.
  always_comb begin
    ram_en   = 1'b0;
    ram_addr = '0;
    ram_d    = '0;
    ram_wbe  = '0;
    if (|grant) begin
      ram_en   = 1'b1;
      ram_addr = AWIDTH'(win_req.addr);
      ram_d    = DWIDTH'(win_req.wdata);
      ram_wbe  = BWIDTH'(win_req.wbe);
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Round-robin pointer hands the next tie to the port that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= other_port(win_idx);
    end
  end
`endif

  sram_arb_port #(.DWIDTH(DWIDTH)) u_port0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (grant[0]),
    .resp_ready   (resp_ready_0),
    .ram_q        (ram_q),
    .eligible_c   (eligible[0]),
    .resp_valid_c (resp_valid_0),
    .resp_rdata_c (resp_rdata_0)
  );

  sram_arb_port #(.DWIDTH(DWIDTH)) u_port1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (grant[1]),
    .resp_ready   (resp_ready_1),
    .ram_q        (ram_q),
    .eligible_c   (eligible[1]),
    .resp_valid_c (resp_valid_1),
    .resp_rdata_c (resp_rdata_1)
  );

endmodule
